// File: rtl/mem_unit_if.sv
// ============================================================================
//  Module      : mem_unit_if
//  Description : Pipeline-request, data-memory and write-back signal bundle
//                for the load/store unit.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dest;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_misalign;
    logic        err_timeout;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_dest,
        input  mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output stall, wb_valid, wb_addr, wb_data, err_misalign, err_timeout
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_dest,
        output mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  stall, wb_valid, wb_addr, wb_data, err_misalign, err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/mem_unit.sv
// ============================================================================
//  Module      : mem_unit
//  Description : Single-outstanding load/store unit with alignment checking,
//                byte-lane steering, load extension and ack timeout.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_unit #(
    parameter int TIMEOUT = 15
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mem_unit_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic               r_we;
    logic               r_signed;
    logic [1:0]         r_size;
    logic [1:0]         r_lane;
    logic [2:0]         r_dest;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [31:0]        r_wb_data;
    logic [2:0]         r_wb_addr;
    logic               r_err_misalign;

    logic               w_misalign;
    logic               w_accept;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;

    assign w_misalign = (bus.req_size == 2'b11)
                      | ((bus.req_size == 2'b01) & bus.req_addr[0])
                      | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));
    assign w_accept   = (r_state == ST_IDLE) & bus.req_valid & ~w_misalign;
    assign w_cnt_inc  = r_cnt + 1'b1;
    // Fires on the TIMEOUT-th consecutive wait cycle; an ack that cycle still wins.
    assign w_timeout  = (r_state == ST_ACCESS) & ~bus.mem_ack
                      & (w_cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            2'd3:    w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        bus.stall       = 1'b0;
        bus.mem_req     = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.err_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.stall = reset & w_accept;
                if (w_accept) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.stall   = 1'b1;
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_state_next = ST_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_DONE: begin
                bus.wb_valid = ~r_we;
                w_state_next = ST_IDLE;
            end
            ST_ERR: begin
                bus.err_timeout = 1'b1;
                w_state_next    = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_we           <= 1'b0;
            r_signed       <= 1'b0;
            r_size         <= 2'b00;
            r_lane         <= 2'b00;
            r_dest         <= 3'd0;
            r_addr         <= 32'd0;
            r_be           <= 4'd0;
            r_wdata        <= 32'd0;
            r_wb_data      <= 32'd0;
            r_wb_addr      <= 3'd0;
            r_err_misalign <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_err_misalign <= (r_state == ST_IDLE) & bus.req_valid & w_misalign;
            if (w_accept) begin
                r_cnt    <= '0;
                r_we     <= bus.req_we;
                r_signed <= bus.req_signed;
                r_size   <= bus.req_size;
                r_lane   <= bus.req_addr[1:0];
                r_dest   <= bus.req_dest;
                r_addr   <= {bus.req_addr[31:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_wdata;
            end else if ((r_state == ST_ACCESS) && !bus.mem_ack) begin
                r_cnt <= w_cnt_inc;
            end
            // Write-back registers change only on load completion so they hold otherwise.
            if ((r_state == ST_ACCESS) && bus.mem_ack && !r_we) begin
                r_wb_data <= w_load_data;
                r_wb_addr <= r_dest;
            end
        end
    end

    assign bus.mem_we       = r_we;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_be       = r_be;
    assign bus.mem_wdata    = r_wdata;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_addr      = r_wb_addr;
    assign bus.err_misalign = r_err_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_unit.sv
// ============================================================================
//  Module      : tb_mem_unit
//  Description : Directed self-checking bench for mem_unit.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_unit_if bus();

    mem_unit #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] dest);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_dest   = dest;
    endtask

    task automatic load_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [2:0] dest, input logic [31:0] rdata,
                            input int waits, input logic [3:0] exp_be, input logic [31:0] exp_data);
        set_req(1'b0, size, sgn, addr, 32'h0, dest);
        bus.mem_ack = 1'b0;
        #1;
        check({tag, " stall_c0"}, 32'(bus.stall), 32'd1);
        check({tag, " req_c0"}, 32'(bus.mem_req), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check({tag, " req_wait"}, 32'(bus.mem_req), 32'd1);
            check({tag, " stall_wait"}, 32'(bus.stall), 32'd1);
            tick();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        #1;
        check({tag, " req_ack"}, 32'(bus.mem_req), 32'd1);
        check({tag, " we"}, 32'(bus.mem_we), 32'd0);
        check({tag, " be"}, 32'(bus.mem_be), 32'(exp_be));
        check({tag, " addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        check({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, " wb_data"}, bus.wb_data, exp_data);
        check({tag, " wb_addr"}, 32'(bus.wb_addr), 32'(dest));
        check({tag, " stall_done"}, 32'(bus.stall), 32'd0);
        check({tag, " err_to"}, 32'(bus.err_timeout), 32'd0);
        tick();
        #1;
        check({tag, " wb_valid_off"}, 32'(bus.wb_valid), 32'd0);
        check({tag, " wb_hold"}, bus.wb_data, exp_data);
    endtask

    task automatic store_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input int waits, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        set_req(1'b1, size, 1'b0, addr, wdata, 3'd6);
        bus.mem_ack = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check({tag, " req_wait"}, 32'(bus.mem_req), 32'd1);
            check({tag, " be_wait"}, 32'(bus.mem_be), 32'(exp_be));
            tick();
        end
        bus.mem_ack = 1'b1;
        #1;
        check({tag, " we"}, 32'(bus.mem_we), 32'd1);
        check({tag, " be"}, 32'(bus.mem_be), 32'(exp_be));
        check({tag, " wdata"}, bus.mem_wdata, exp_wdata);
        check({tag, " addr"}, bus.mem_addr, exp_addr);
        check({tag, " stall_ack"}, 32'(bus.stall), 32'd1);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd0);
        check({tag, " stall_done"}, 32'(bus.stall), 32'd0);
        check({tag, " req_done"}, 32'(bus.mem_req), 32'd0);
        tick();
    endtask

    task automatic misalign_txn(input string tag, input logic [1:0] size, input logic [31:0] addr);
        set_req(1'b0, size, 1'b0, addr, 32'h0, 3'd1);
        #1;
        check({tag, " stall"}, 32'(bus.stall), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check({tag, " err"}, 32'(bus.err_misalign), 32'd1);
        check({tag, " req"}, 32'(bus.mem_req), 32'd0);
        tick();
        #1;
        check({tag, " err_off"}, 32'(bus.err_misalign), 32'd0);
        check({tag, " req_after"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_dest   = 3'd0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ack    = 1'b0;

        // Reset state, including stall held low with a legal request pending
        #2;
        set_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3'd1);
        #1;
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst stall", 32'(bus.stall), 32'd0);
        check("rst mem_be", 32'(bus.mem_be), 32'd0);
        check("rst wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst wb_data", bus.wb_data, 32'd0);
        check("rst err_mis", 32'(bus.err_misalign), 32'd0);
        check("rst err_to", 32'(bus.err_timeout), 32'd0);
        bus.req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        load_txn("ld_word",   32'h100, 2'b10, 1'b0, 3'd1, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF);
        load_txn("ld_sbyte",  32'h103, 2'b00, 1'b1, 3'd2, 32'h80112233, 0, 4'b1000, 32'hFFFFFF80);
        load_txn("ld_ubyte",  32'h103, 2'b00, 1'b0, 3'd3, 32'h80112233, 2, 4'b1000, 32'h00000080);
        load_txn("ld_shalf",  32'h102, 2'b01, 1'b1, 3'd4, 32'h80112233, 1, 4'b1100, 32'hFFFF8011);
        load_txn("ld_uhalf",  32'h100, 2'b01, 1'b0, 3'd5, 32'h80112233, 0, 4'b0011, 32'h00002233);
        load_txn("ld_byte1",  32'h101, 2'b00, 1'b1, 3'd6, 32'h80112233, 0, 4'b0010, 32'h00000022);
        load_txn("ld_byte0",  32'h100, 2'b00, 1'b1, 3'd7, 32'h123456F0, 0, 4'b0001, 32'hFFFFFFF0);

        store_txn("st_half",  32'h202, 2'b01, 32'h0000ABCD, 3, 4'b1100, 32'hABCDABCD, 32'h200);
        store_txn("st_byte",  32'h001, 2'b00, 32'h123456A5, 0, 4'b0010, 32'hA5A5A5A5, 32'h000);
        store_txn("st_word",  32'h204, 2'b10, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, 32'h204);
        #1;
        check("st wb_data hold", bus.wb_data, 32'hFFFFFFF0);
        check("st wb_addr hold", 32'(bus.wb_addr), 32'd7);

        misalign_txn("mis_word", 2'b10, 32'h102);
        misalign_txn("mis_half", 2'b01, 32'h101);
        misalign_txn("mis_size", 2'b11, 32'h100);

        // Ack never arrives: 15 wait cycles then the error pulse
        set_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 3'd2);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("to req_wait", 32'(bus.mem_req), 32'd1);
            check("to err_early", 32'(bus.err_timeout), 32'd0);
            tick();
        end
        #1;
        check("to err_pulse", 32'(bus.err_timeout), 32'd1);
        check("to req_drop", 32'(bus.mem_req), 32'd0);
        check("to wb_valid", 32'(bus.wb_valid), 32'd0);
        check("to stall", 32'(bus.stall), 32'd0);
        tick();
        #1;
        check("to err_off", 32'(bus.err_timeout), 32'd0);
        check("to req_after", 32'(bus.mem_req), 32'd0);
        tick();

        // Ack on the final permitted wait cycle completes normally
        load_txn("ld_ack_edge", 32'h300, 2'b10, 1'b0, 3'd3, 32'h0BADF00D, 14, 4'b1111, 32'h0BADF00D);

        // Asynchronous reset in the middle of an access
        set_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 3'd5);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("ar req_before", 32'(bus.mem_req), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("ar req", 32'(bus.mem_req), 32'd0);
        check("ar addr", bus.mem_addr, 32'd0);
        check("ar be", 32'(bus.mem_be), 32'd0);
        check("ar wb_data", bus.wb_data, 32'd0);
        check("ar wb_addr", 32'(bus.wb_addr), 32'd0);
        check("ar stall", 32'(bus.stall), 32'd0);
        tick();
        reset = 1'b1;
        load_txn("ld_post_rst", 32'h404, 2'b10, 1'b0, 3'd7, 32'h13579BDF, 1, 4'b1111, 32'h13579BDF);
        #1;
        check("post_rst err_to", 32'(bus.err_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
